// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_er,
    input  logic [4:0] ex_aw,
    output logic       lu
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_aw == id_rs);
    assign rt_match = id_uses_rt && (ex_aw == id_rt);
    // Writes to $zero are discarded, so they can never feed a dependent instruction.
    assign lu       = ex_er && (ex_aw != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Run/halt/step sequencer with load-use bubble insertion, redirect squash and
// saturating debug counters for the five-stage core.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic             step,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_er,
    input  logic [4:0]       ex_aw,
    input  logic             mem_redirect,
    output logic             pc_en,
    output logic             b1_en,
    output logic             b2_en,
    output logic             b3_en,
    output logic             b4_en,
    output logic             b1_flush,
    output logic             b2_flush,
    output logic             b3_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu;
    logic             advancing;
    logic             redirect_cyc;
    logic             stall_cyc;

    hazard_detect u_hazard (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_er      (ex_er),
        .ex_aw      (ex_aw),
        .lu         (lu)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (run) state_d = ST_RUN;
            ST_RUN:  if (halt_req) state_d = ST_HALT;
            ST_HALT: begin
                if (step)                  state_d = ST_STEP;
                else if (run && !halt_req) state_d = ST_RUN;
            end
            ST_STEP: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset is folded in so the pipeline is already quiesced during the reset cycle.
    assign advancing    = !rst && (state_q == ST_RUN || state_q == ST_STEP);
    assign redirect_cyc = advancing && mem_redirect;
    assign stall_cyc    = advancing && !mem_redirect && lu;

    always_comb begin
        pc_en    = 1'b0;
        b1_en    = 1'b0;
        b2_en    = 1'b0;
        b3_en    = 1'b0;
        b4_en    = 1'b0;
        b1_flush = 1'b0;
        b2_flush = 1'b0;
        b3_flush = 1'b0;
        if (rst || state_q == ST_IDLE) begin
            b1_flush = 1'b1;
            b2_flush = 1'b1;
            b3_flush = 1'b1;
        end else if (advancing) begin
            b2_en = 1'b1;
            b3_en = 1'b1;
            b4_en = 1'b1;
            if (redirect_cyc) begin
                pc_en    = 1'b1;
                b1_en    = 1'b1;
                b1_flush = 1'b1;
                b2_flush = 1'b1;
                b3_flush = 1'b1;
            end else if (stall_cyc) begin
                b2_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
                b1_en = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cyc && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + 1'b1;
        if (redirect_cyc && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a 4-bit counter build to reach saturation quickly.
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst, run, halt_req, step, id_uses_rt, ex_er, mem_redirect;
    logic [4:0]       id_rs, id_rt, ex_aw;
    logic             pc_en, b1_en, b2_en, b3_en, b4_en;
    logic             b1_flush, b2_flush, b3_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .halt_req     (halt_req),
        .step         (step),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_er        (ex_er),
        .ex_aw        (ex_aw),
        .mem_redirect (mem_redirect),
        .pc_en        (pc_en),
        .b1_en        (b1_en),
        .b2_en        (b2_en),
        .b3_en        (b3_en),
        .b4_en        (b4_en),
        .b1_flush     (b1_flush),
        .b2_flush     (b2_flush),
        .b3_flush     (b3_flush),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] en, input logic [2:0] fl);
        #1;
        chk({tag, "_en"}, {27'd0, pc_en, b1_en, b2_en, b3_en, b4_en}, {27'd0, en});
        chk({tag, "_fl"}, {29'd0, b1_flush, b2_flush, b3_flush}, {29'd0, fl});
        $display("step %s: state=%0d en=%b fl=%b stall=%0d flush=%0d", tag, state,
                 {pc_en, b1_en, b2_en, b3_en, b4_en}, {b1_flush, b2_flush, b3_flush},
                 stall_cnt, flush_cnt);
    endtask

    task automatic clear_hazard();
        ex_er = 0; ex_aw = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; mem_redirect = 0;
    endtask

    initial begin
        rst = 1; run = 0; halt_req = 0; step = 0;
        clear_hazard();
        tick(); tick();
        chk_out("in_reset", 5'b00000, 3'b111);
        chk("in_reset_state", 32'(state), 32'd0);

        rst = 0;
        for (int i = 0; i < 3; i++) tick();
        chk_out("idle", 5'b00000, 3'b111);
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_stall", 32'(stall_cnt), 32'd0);
        chk("idle_flush", 32'(flush_cnt), 32'd0);

        run = 1;
        tick();
        chk("run_state", 32'(state), 32'd1);
        chk_out("run", 5'b11111, 3'b000);

        ex_er = 1; ex_aw = 5; id_rs = 5;
        chk_out("lu_rs", 5'b00111, 3'b010);
        tick();
        chk("lu_rs_cnt", 32'(stall_cnt), 32'd1);

        ex_aw = 0; id_rs = 0;
        chk_out("lu_r0", 5'b11111, 3'b000);
        tick();
        chk("lu_r0_cnt", 32'(stall_cnt), 32'd1);

        ex_aw = 7; id_rt = 7; id_rs = 3; id_uses_rt = 0;
        chk_out("rt_unused", 5'b11111, 3'b000);
        id_uses_rt = 1;
        chk_out("lu_rt", 5'b00111, 3'b010);
        tick();
        chk("lu_rt_cnt", 32'(stall_cnt), 32'd2);

        ex_aw = 5; id_rs = 5; id_uses_rt = 0; mem_redirect = 1;
        chk_out("redir_lu", 5'b11111, 3'b111);
        tick();
        chk("redir_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("redir_stall_cnt", 32'(stall_cnt), 32'd2);

        halt_req = 1;
        chk_out("redir_halt", 5'b11111, 3'b111);
        tick();
        chk("halt_state", 32'(state), 32'd2);
        chk("halt_flush_cnt", 32'(flush_cnt), 32'd2);
        chk_out("halt", 5'b00000, 3'b000);

        mem_redirect = 0; halt_req = 0; run = 0;
        step = 1;
        tick();
        step = 0;
        chk("step_state", 32'(state), 32'd3);
        chk_out("step_lu", 5'b00111, 3'b010);
        tick();
        chk("step_back", 32'(state), 32'd2);
        chk("step_stall_cnt", 32'(stall_cnt), 32'd3);
        chk_out("step_back", 5'b00000, 3'b000);
        clear_hazard();

        run = 1; halt_req = 1;
        tick();
        chk("halt_wins", 32'(state), 32'd2);
        halt_req = 0;
        tick();
        chk("resume", 32'(state), 32'd1);

        step = 1;
        tick();
        step = 0;
        chk("step_in_run", 32'(state), 32'd1);

        mem_redirect = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("flush_sat", 32'(flush_cnt), 32'd15);
        chk("sat_state", 32'(state), 32'd1);

        rst = 1;
        chk_out("rst_mid", 5'b00000, 3'b111);
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);
        rst = 0; mem_redirect = 0; run = 0;
        tick();
        chk("post_rst", 32'(state), 32'd0);
        chk_out("post_rst", 5'b00000, 3'b111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
